ram_writer: RTL

Accepts one AXI-Stream packet, delimited by TLAST, and writes it to RAM through the AW/W/B channels of an AXI4 master.
- Writes start at RAM_BASE_ADDR, in bursts of CYCLES_PER_RAM_BLOCK beats.
- The final block is padded with zero-strobe beats up to the full burst length.
- Reports full_blocks and partial_block_cycles in the form the RAM read-back path consumes to replay the packet.

---
 rtl/ram_writer_if.sv | 82 ++++++++
 rtl/ram_writer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/ram_writer_if.sv
// AXI-Stream input plus AXI4 write-master bundle for ram_writer.
// master: the ram_writer side. slave: the stream source and memory model side.
interface ram_writer_if #(
  parameter int DW = 512
);
  // Stream input
  logic [DW-1:0]   AXIS_IN_TDATA;
  logic            AXIS_IN_TVALID;
  logic            AXIS_IN_TLAST;
  logic            AXIS_IN_TREADY;
  // Write address channel
  logic [63:0]     M_AXI_AWADDR;
  logic [7:0]      M_AXI_AWLEN;
  logic [2:0]      M_AXI_AWSIZE;
  logic [1:0]      M_AXI_AWBURST;
  logic [3:0]      M_AXI_AWID;
  logic [3:0]      M_AXI_AWCACHE;
  logic [3:0]      M_AXI_AWQOS;
  logic            M_AXI_AWLOCK;
  logic [2:0]      M_AXI_AWPROT;
  logic            M_AXI_AWVALID;
  logic            M_AXI_AWREADY;
  // Write data channel
  logic [DW-1:0]   M_AXI_WDATA;
  logic [DW/8-1:0] M_AXI_WSTRB;
  logic            M_AXI_WLAST;
  logic            M_AXI_WVALID;
  logic            M_AXI_WREADY;
  // Write response channel
  logic [1:0]      M_AXI_BRESP;
  logic            M_AXI_BVALID;
  logic            M_AXI_BREADY;
  // Read channels (not used by the writer)
  logic [63:0]     M_AXI_ARADDR;
  logic [7:0]      M_AXI_ARLEN;
  logic [2:0]      M_AXI_ARSIZE;
  logic [1:0]      M_AXI_ARBURST;
  logic [3:0]      M_AXI_ARID;
  logic [3:0]      M_AXI_ARCACHE;
  logic [3:0]      M_AXI_ARQOS;
  logic            M_AXI_ARLOCK;
  logic [2:0]      M_AXI_ARPROT;
  logic            M_AXI_ARVALID;
  logic            M_AXI_ARREADY;
  logic [DW-1:0]   M_AXI_RDATA;
  logic [1:0]      M_AXI_RRESP;
  logic            M_AXI_RLAST;
  logic            M_AXI_RVALID;
  logic            M_AXI_RREADY;

  modport master (
    input  AXIS_IN_TDATA, AXIS_IN_TVALID, AXIS_IN_TLAST,
    output AXIS_IN_TREADY,
    output M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST, M_AXI_AWID,
           M_AXI_AWCACHE, M_AXI_AWQOS, M_AXI_AWLOCK, M_AXI_AWPROT, M_AXI_AWVALID,
    input  M_AXI_AWREADY,
    output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, M_AXI_WVALID,
    input  M_AXI_WREADY,
    input  M_AXI_BRESP, M_AXI_BVALID,
    output M_AXI_BREADY,
    output M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST, M_AXI_ARID,
           M_AXI_ARCACHE, M_AXI_ARQOS, M_AXI_ARLOCK, M_AXI_ARPROT, M_AXI_ARVALID,
    input  M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST, M_AXI_RVALID,
    output M_AXI_RREADY
  );

  modport slave (
    output AXIS_IN_TDATA, AXIS_IN_TVALID, AXIS_IN_TLAST,
    input  AXIS_IN_TREADY,
    input  M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST, M_AXI_AWID,
           M_AXI_AWCACHE, M_AXI_AWQOS, M_AXI_AWLOCK, M_AXI_AWPROT, M_AXI_AWVALID,
    output M_AXI_AWREADY,
    input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, M_AXI_WVALID,
    output M_AXI_WREADY,
    output M_AXI_BRESP, M_AXI_BVALID,
    input  M_AXI_BREADY,
    input  M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST, M_AXI_ARID,
           M_AXI_ARCACHE, M_AXI_ARQOS, M_AXI_ARLOCK, M_AXI_ARPROT, M_AXI_ARVALID,
    output M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST, M_AXI_RVALID,
    input  M_AXI_RREADY
  );
endinterface

// File: rtl/ram_writer.sv
// ram_writer: captures one AXI-Stream packet (TLAST delimited) into RAM as
// fixed-length INCR bursts starting at RAM_BASE_ADDR. The last block is padded
// with zero-strobe beats; data beyond RAM_BLOCKS blocks is drained and dropped.
// Optional feature macro: RAM_WRITER_BRESP_CHECK_EN (sticky BRESP error flag).
//
// Handshakes: every channel transfers on a cycle where valid and ready are both
// high at the rising clock edge; valid never depends on ready of the same
// channel, and the stream TREADY is a combinational copy of WREADY while
// data passes through.
module ram_writer #(
  parameter int          DW                   = 512,
  parameter int          CHANNEL              = 0,
  parameter logic [63:0] RAM_BASE_ADDR        = 64'h0,
  parameter int          CYCLES_PER_RAM_BLOCK = 64,
  parameter int          RAM_BLOCKS           = 1024
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  output logic        idle,
  output logic [31:0] full_blocks,
  output logic [7:0]  partial_block_cycles,
  output logic        overflow,
  output logic        bresp_error,
  output logic [2:0]  fsm_state,
  ram_writer_if.master bus
);

  localparam logic [7:0]  LAST_BEAT   = 8'(CYCLES_PER_RAM_BLOCK - 1);
  localparam logic [63:0] BLOCK_BYTES = 64'(CYCLES_PER_RAM_BLOCK) * 64'(DW / 8);
  localparam logic [31:0] MAX_BLOCKS  = 32'(RAM_BLOCKS);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    AW      = 3'd1,
    DATA    = 3'd2,
    PAD     = 3'd3,
    DISCARD = 3'd4,
    WAIT_B  = 3'd5
  } state_t;

  state_t          state, state_n;
  logic [31:0]     blk;
  logic [7:0]      beat;
  logic [31:0]     bcnt, bcnt_n;
  logic [63:0]     awaddr;

  logic            awvalid, wvalid, wlast, tready;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;
  logic            w_fire, b_fire;

  assign w_fire = wvalid & bus.M_AXI_WREADY;
  assign b_fire = bus.M_AXI_BVALID & (state != IDLE);
  assign bcnt_n = bcnt + {31'd0, b_fire};

  // Next-state and channel outputs for the current state.
  always_comb begin
    state_n = state;
    awvalid = 1'b0;
    wvalid  = 1'b0;
    wdata   = '0;
    wstrb   = '0;
    tready  = 1'b0;
    wlast   = (beat == LAST_BEAT);
    case (state)
      IDLE: begin
        if (start) state_n = AW;
      end
      AW: begin
        awvalid = 1'b1;
        if (bus.M_AXI_AWREADY) state_n = DATA;
      end
      DATA: begin
        wvalid = bus.AXIS_IN_TVALID;
        tready = bus.M_AXI_WREADY;
        wdata  = bus.AXIS_IN_TDATA;
        wstrb  = '1;
        if (w_fire) begin
          if (wlast && !bus.AXIS_IN_TLAST)
            state_n = (blk == MAX_BLOCKS) ? DISCARD : AW;
          else if (wlast)
            state_n = WAIT_B;
          else if (bus.AXIS_IN_TLAST)
            state_n = PAD;
        end
      end
      PAD: begin
        wvalid = 1'b1;
        if (w_fire && wlast) state_n = WAIT_B;
      end
      DISCARD: begin
        tready = 1'b1;
        if (bus.AXIS_IN_TVALID && bus.AXIS_IN_TLAST) state_n = WAIT_B;
      end
      WAIT_B: begin
        if (bcnt_n == blk) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // State register plus block/beat/response counters and status.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state                <= IDLE;
      blk                  <= '0;
      beat                 <= '0;
      bcnt                 <= '0;
      awaddr               <= '0;
      full_blocks          <= '0;
      partial_block_cycles <= '0;
      overflow             <= 1'b0;
    end else begin
      state <= state_n;
      if (state != IDLE) bcnt <= bcnt_n;
      case (state)
        IDLE: begin
          if (start) begin
            blk                  <= '0;
            beat                 <= '0;
            bcnt                 <= '0;
            full_blocks          <= '0;
            partial_block_cycles <= '0;
            overflow             <= 1'b0;
            awaddr               <= RAM_BASE_ADDR;
          end
        end
        AW: begin
          if (bus.M_AXI_AWREADY) begin
            blk  <= blk + 32'd1;
            beat <= '0;
          end
        end
        DATA: begin
          if (w_fire) begin
            beat <= beat + 8'd1;
            if (wlast) full_blocks <= full_blocks + 32'd1;
            if (wlast && !bus.AXIS_IN_TLAST) begin
              awaddr <= awaddr + BLOCK_BYTES;
              if (blk == MAX_BLOCKS) overflow <= 1'b1;
            end
            if (bus.AXIS_IN_TLAST && !wlast) partial_block_cycles <= beat + 8'd1;
          end
        end
        PAD: begin
          if (w_fire) beat <= beat + 8'd1;
        end
        default: ;
      endcase
    end
  end

`ifdef RAM_WRITER_BRESP_CHECK_EN
  // Sticky flag for any error response; only a new capture clears it.
  always_ff @(posedge clk) begin
    if (!resetn)
      bresp_error <= 1'b0;
    else if (state == IDLE && start)
      bresp_error <= 1'b0;
    else if (b_fire && bus.M_AXI_BRESP != 2'b00)
      bresp_error <= 1'b1;
  end
`else
  assign bresp_error = 1'b0;
`endif

  assign idle      = (state == IDLE) & ~start;
  assign fsm_state = state;

  assign bus.AXIS_IN_TREADY = tready;

  assign bus.M_AXI_AWADDR  = awaddr;
  assign bus.M_AXI_AWLEN   = LAST_BEAT;
  assign bus.M_AXI_AWSIZE  = 3'($clog2(DW / 8));
  assign bus.M_AXI_AWBURST = 2'b01;
  assign bus.M_AXI_AWID    = '0;
  assign bus.M_AXI_AWCACHE = '0;
  assign bus.M_AXI_AWQOS   = '0;
  assign bus.M_AXI_AWLOCK  = 1'b0;
  assign bus.M_AXI_AWPROT  = '0;
  assign bus.M_AXI_AWVALID = awvalid;

  assign bus.M_AXI_WDATA  = wdata;
  assign bus.M_AXI_WSTRB  = wstrb;
  assign bus.M_AXI_WLAST  = wlast;
  assign bus.M_AXI_WVALID = wvalid;

  assign bus.M_AXI_BREADY = (state != IDLE);

  assign bus.M_AXI_ARADDR  = '0;
  assign bus.M_AXI_ARLEN   = '0;
  assign bus.M_AXI_ARSIZE  = '0;
  assign bus.M_AXI_ARBURST = '0;
  assign bus.M_AXI_ARID    = '0;
  assign bus.M_AXI_ARCACHE = '0;
  assign bus.M_AXI_ARQOS   = '0;
  assign bus.M_AXI_ARLOCK  = 1'b0;
  assign bus.M_AXI_ARPROT  = '0;
  assign bus.M_AXI_ARVALID = 1'b0;
  assign bus.M_AXI_RREADY  = 1'b0;

  // Read-side inputs and the channel tag have no function in the writer.
  logic unused_ok;
  assign unused_ok = ^{bus.M_AXI_ARREADY, bus.M_AXI_RDATA, bus.M_AXI_RRESP,
                       bus.M_AXI_RLAST, bus.M_AXI_RVALID, bus.M_AXI_BRESP,
                       32'(CHANNEL)};

endmodule
